// File: rtl/alu_pkg.sv
// alu_pkg
// Shared types and default widths for the ALU datapath blocks.
//   state_t : sequencing states of the multiply-accumulate consumer
//   OP_MUL  : ALU opcode of the 3x3 multiplier that feeds the accumulator
//   MUL_W   : width of a multiplier product (3x3 -> 6 bits)
//   ACC_W   : default accumulator width (8 x 49 = 392 fits in 9 bits)
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_MUL = 2'b11;
  localparam int         MUL_W  = 6;
  localparam int         ACC_W  = 9;

endpackage

// File: rtl/alu_sat_add.sv
// alu_sat_add
// Unsigned saturating adder, purely combinational.
//   a, b : W-bit unsigned operands
//   sum  : a + b, clamped to 2^W-1 when the true sum does not fit
//   sat  : high when clamping happened (carry out of the W-bit add)
module alu_sat_add #(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         sat
);

  logic [W:0] w_full;

  // One extra bit so the carry-out can flag saturation.
  assign w_full = {1'b0, a} + {1'b0, b};
  assign sat    = w_full[W];
  assign sum    = w_full[W] ? {W{1'b1}} : w_full[W-1:0];

endmodule

// File: rtl/alu_mac_accum.sv
// alu_mac_accum
// Sums a programmed number of consecutive multiplier products into a
// saturating accumulator and presents the total on a valid/ready port.
//   clk, rst        : rising-edge clock, async active-high reset
//   clr             : synchronous abort back to IDLE, highest priority
//   start, len      : begin a run of len terms (len==0 means 2^CNT_W)
//   din_valid/din   : product stream in; din_ready high only in ACCUM
//   dout_valid/dout : result port, held in DONE until dout_ready
//   dout_ovf        : saturation occurred during this run
//   busy            : high in ACCUM or DONE
//
//   state    | meaning
//   ---------+---------------------------------------------------
//   ST_IDLE  | waiting for start, din not accepted
//   ST_ACCUM | accepting products, counting terms
//   ST_DONE  | result presented; dout_ready+start hands off to ACCUM
module alu_mac_accum #(
  parameter int DIN_W = alu_pkg::MUL_W,
  parameter int ACC_W = alu_pkg::ACC_W,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             din_valid,
  input  logic [DIN_W-1:0] din,
  output logic             din_ready,
  output logic             dout_valid,
  output logic [ACC_W-1:0] dout,
  output logic             dout_ovf,
  input  logic             dout_ready,
  output logic             busy
);

  import alu_pkg::*;

  localparam logic [CNT_W:0] FULL_TERMS = {1'b1, {CNT_W{1'b0}}};
  localparam logic [CNT_W:0] CNT_ONE    = {{CNT_W{1'b0}}, 1'b1};

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W:0]   r_cnt;
  logic [CNT_W:0]   r_terms;
  logic             r_ovf;

  logic [ACC_W-1:0] w_din_ext;
  logic [ACC_W-1:0] w_sum;
  logic             w_sat;
  logic             w_last;
  logic [CNT_W:0]   w_len_terms;

  assign w_din_ext   = ACC_W'(din);
  assign w_len_terms = (len == '0) ? FULL_TERMS : {1'b0, len};
  assign w_last      = (r_cnt == (r_terms - CNT_ONE));

  alu_sat_add #(.W(ACC_W)) u_add (
    .a   (r_acc),
    .b   (w_din_ext),
    .sum (w_sum),
    .sat (w_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_terms <= '0;
      r_ovf   <= 1'b0;
    end else if (clr) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_terms <= w_len_terms;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (din_valid) begin
            r_acc <= w_sum;
            r_ovf <= r_ovf | w_sat;
            r_cnt <= r_cnt + CNT_ONE;
            if (w_last) r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (dout_ready) begin
            if (start) begin
              // Zero-bubble handoff straight into the next run.
              r_terms <= w_len_terms;
              r_acc   <= '0;
              r_cnt   <= '0;
              r_ovf   <= 1'b0;
              r_state <= ST_ACCUM;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Outputs come only from registered state, never from inputs.
  assign din_ready  = (r_state == ST_ACCUM);
  assign dout_valid = (r_state == ST_DONE);
  assign dout       = (r_state == ST_DONE) ? r_acc : '0;
  assign dout_ovf   = (r_state == ST_DONE) & r_ovf;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_mac_accum.sv
module tb_alu_mac_accum;

  logic       clk;
  logic       rst;

  logic       clr, start, din_valid, dout_ready;
  logic [2:0] len;
  logic [5:0] din;
  logic       din_ready, dout_valid, dout_ovf, busy;
  logic [8:0] dout;

  logic       s_clr, s_start, s_din_valid, s_dout_ready;
  logic [2:0] s_len;
  logic [5:0] s_din;
  logic       s_din_ready, s_dout_valid, s_dout_ovf, s_busy;
  logic [5:0] s_dout;

  int checks = 0;
  int errors = 0;

  alu_mac_accum u_dut (
    .clk(clk), .rst(rst), .clr(clr), .start(start), .len(len),
    .din_valid(din_valid), .din(din), .din_ready(din_ready),
    .dout_valid(dout_valid), .dout(dout), .dout_ovf(dout_ovf),
    .dout_ready(dout_ready), .busy(busy)
  );

  alu_mac_accum #(.DIN_W(6), .ACC_W(6), .CNT_W(3)) u_sat (
    .clk(clk), .rst(rst), .clr(s_clr), .start(s_start), .len(s_len),
    .din_valid(s_din_valid), .din(s_din), .din_ready(s_din_ready),
    .dout_valid(s_dout_valid), .dout(s_dout), .dout_ovf(s_dout_ovf),
    .dout_ready(s_dout_ready), .busy(s_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       st;
    logic [2:0] ln;
    logic       dv;
    logic [5:0] d;
    logic       dr;
    logic       cl;
    logic       e_rdy;
    logic       e_vld;
    logic [8:0] e_dout;
    logic       e_ovf;
    logic       e_busy;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic st, input logic [2:0] ln, input logic dv,
                     input logic [5:0] d, input logic dr, input logic cl);
    start = st; len = ln; din_valid = dv; din = d; dout_ready = dr; clr = cl;
  endtask

  task automatic sdrv(input logic st, input logic [2:0] ln, input logic dv,
                      input logic [5:0] d, input logic dr);
    s_start = st; s_len = ln; s_din_valid = dv; s_din = d; s_dout_ready = dr;
    s_clr = 1'b0;
  endtask

  task automatic chk_all(input string tag, input int rdy, input int vld,
                         input int dv, input int ov, input int bs);
    chk({tag, " din_ready"}, int'(din_ready), rdy);
    chk({tag, " dout_valid"}, int'(dout_valid), vld);
    chk({tag, " dout"}, int'(dout), dv);
    chk({tag, " dout_ovf"}, int'(dout_ovf), ov);
    chk({tag, " busy"}, int'(busy), bs);
  endtask

  initial begin
    // st ln dv d dr cl | rdy vld dout ovf busy
    vecs[0]  = '{1'b0, 3'd0, 1'b1, 6'd20, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0,  1'b0, 1'b0};
    vecs[1]  = '{1'b1, 3'd3, 1'b0, 6'd0,  1'b0, 1'b0, 1'b1, 1'b0, 9'd0,  1'b0, 1'b1};
    vecs[2]  = '{1'b0, 3'd0, 1'b1, 6'd49, 1'b0, 1'b0, 1'b1, 1'b0, 9'd0,  1'b0, 1'b1};
    vecs[3]  = '{1'b1, 3'd1, 1'b1, 6'd6,  1'b0, 1'b0, 1'b1, 1'b0, 9'd0,  1'b0, 1'b1};
    vecs[4]  = '{1'b0, 3'd0, 1'b0, 6'd0,  1'b0, 1'b0, 1'b1, 1'b0, 9'd0,  1'b0, 1'b1};
    vecs[5]  = '{1'b0, 3'd0, 1'b1, 6'd10, 1'b0, 1'b0, 1'b0, 1'b1, 9'd65, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 3'd2, 1'b1, 6'd3,  1'b0, 1'b0, 1'b0, 1'b1, 9'd65, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 3'd0, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 1'b1, 9'd65, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 3'd0, 1'b1, 6'd9,  1'b0, 1'b0, 1'b0, 1'b1, 9'd65, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 3'd0, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 1'b1, 9'd65, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 3'd0, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 1'b1, 9'd65, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 3'd1, 1'b0, 6'd0,  1'b1, 1'b0, 1'b1, 1'b0, 9'd0,  1'b0, 1'b1};
    vecs[12] = '{1'b0, 3'd0, 1'b1, 6'd33, 1'b0, 1'b0, 1'b0, 1'b1, 9'd33, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 3'd0, 1'b0, 6'd0,  1'b1, 1'b0, 1'b0, 1'b0, 9'd0,  1'b0, 1'b0};

    rst = 1'b1;
    drv(1'b0, 3'd0, 1'b0, 6'd0, 1'b0, 1'b0);
    sdrv(1'b0, 3'd0, 1'b0, 6'd0, 1'b0);
    tick();
    tick();
    chk_all("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Basic MAC, backpressure and zero-bubble handoff.
    for (int i = 0; i < 14; i++) begin
      drv(vecs[i].st, vecs[i].ln, vecs[i].dv, vecs[i].d, vecs[i].dr, vecs[i].cl);
      tick();
      chk_all($sformatf("vec%0d", i), int'(vecs[i].e_rdy), int'(vecs[i].e_vld),
              int'(vecs[i].e_dout), int'(vecs[i].e_ovf), int'(vecs[i].e_busy));
    end

    // len=0 -> 8 terms of 49 with a bubble after each.
    drv(1'b1, 3'd0, 1'b0, 6'd0, 1'b0, 1'b0);
    tick();
    chk("len0 start busy", int'(busy), 1);
    for (int t = 0; t < 8; t++) begin
      drv(1'b0, 3'd0, 1'b1, 6'd49, 1'b0, 1'b0);
      tick();
      if (t < 7) begin
        chk($sformatf("len0 term%0d not done", t), int'(dout_valid), 0);
        drv(1'b0, 3'd0, 1'b0, 6'd0, 1'b0, 1'b0);
        tick();
        chk($sformatf("len0 bubble%0d ready", t), int'(din_ready), 1);
      end
    end
    chk_all("len0 done", 0, 1, 392, 0, 1);
    drv(1'b0, 3'd0, 1'b0, 6'd0, 1'b1, 1'b0);
    tick();
    chk("len0 taken busy", int'(busy), 0);

    // Saturation on the 6-bit accumulator instance.
    sdrv(1'b1, 3'd2, 1'b0, 6'd0, 1'b0); tick();
    sdrv(1'b0, 3'd0, 1'b1, 6'd49, 1'b0); tick();
    sdrv(1'b0, 3'd0, 1'b1, 6'd49, 1'b0); tick();
    chk("sat1 valid", int'(s_dout_valid), 1);
    chk("sat1 dout", int'(s_dout), 63);
    chk("sat1 ovf", int'(s_dout_ovf), 1);
    sdrv(1'b1, 3'd1, 1'b0, 6'd0, 1'b1); tick();
    chk("sat2 handoff ready", int'(s_din_ready), 1);
    sdrv(1'b0, 3'd0, 1'b1, 6'd5, 1'b0); tick();
    chk("sat2 dout", int'(s_dout), 5);
    chk("sat2 ovf cleared", int'(s_dout_ovf), 0);
    sdrv(1'b1, 3'd3, 1'b0, 6'd0, 1'b1); tick();
    sdrv(1'b0, 3'd0, 1'b1, 6'd40, 1'b0); tick();
    sdrv(1'b0, 3'd0, 1'b1, 6'd40, 1'b0); tick();
    sdrv(1'b0, 3'd0, 1'b1, 6'd2, 1'b0); tick();
    chk("sat3 dout held max", int'(s_dout), 63);
    chk("sat3 ovf sticky", int'(s_dout_ovf), 1);
    sdrv(1'b0, 3'd0, 1'b0, 6'd0, 1'b1); tick();
    chk("sat3 taken busy", int'(s_busy), 0);

    // Abort after 2 of 4 terms, start and din also high on the clr cycle.
    drv(1'b1, 3'd4, 1'b0, 6'd0, 1'b0, 1'b0); tick();
    drv(1'b0, 3'd0, 1'b1, 6'd3, 1'b0, 1'b0); tick();
    drv(1'b0, 3'd0, 1'b1, 6'd4, 1'b0, 1'b0); tick();
    drv(1'b1, 3'd1, 1'b1, 6'd9, 1'b1, 1'b1); tick();
    chk_all("clr", 0, 0, 0, 0, 0);
    drv(1'b0, 3'd0, 1'b1, 6'd9, 1'b0, 1'b0); tick();
    chk("clr stays idle", int'(busy), 0);
    drv(1'b1, 3'd1, 1'b0, 6'd0, 1'b0, 1'b0); tick();
    drv(1'b0, 3'd0, 1'b1, 6'd7, 1'b0, 1'b0); tick();
    chk_all("after clr", 0, 1, 7, 0, 1);
    drv(1'b0, 3'd0, 1'b0, 6'd0, 1'b1, 1'b0); tick();

    // Asynchronous reset in the middle of a cycle during ACCUM.
    drv(1'b1, 3'd2, 1'b0, 6'd0, 1'b0, 1'b0); tick();
    drv(1'b0, 3'd0, 1'b1, 6'd5, 1'b0, 1'b0); tick();
    chk("pre-rst busy", int'(busy), 1);
    drv(1'b0, 3'd0, 1'b0, 6'd0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async rst", 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    drv(1'b0, 3'd0, 1'b1, 6'd5, 1'b0, 1'b0); tick();
    chk("post-rst idle", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mac_accum.md
Name: alu_mac_accum

Overview:
- Downstream consumer of the 3x3 ALU multiplier's 6-bit product stream.
- Sums a programmed number of consecutive products into a saturating accumulator, then presents the total on a valid/ready output port.
- Gives the ALU a multiply-accumulate (dot-product) capability without changing the multiplier stage.

Parameters:
- DIN_W, 6, width of each incoming product.
- ACC_W, 9, accumulator and result width. 8 x 49 = 392 fits at default; saturation applies for narrower settings.
- CNT_W, 3, width of the term-count field.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- clr  in  1  synchronous abort; returns the block to IDLE.
- start  in  1  begin a new accumulation; sampled only in IDLE, or in DONE on the handoff cycle.
- len  in  CNT_W  number of terms, latched on start. 0 means 2^CNT_W terms.
- din_valid  in  1  product on din is valid.
- din  in  DIN_W  unsigned product from the multiplier.
- din_ready  out  1  block accepts din this cycle.
- dout_valid  out  1  result available.
- dout  out  ACC_W  accumulated result.
- dout_ovf  out  1  saturation occurred during this accumulation.
- dout_ready  in  1  consumer takes the result.
- busy  out  1  high in ACCUM or DONE.

Behaviour:
- Reset (rst=1, async): state=IDLE, acc=0, cnt=0, ovf=0, din_ready=0, dout_valid=0, dout=0, dout_ovf=0, busy=0.
- All outputs are registered or decoded from state only; there are no combinational input-to-output paths.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - din_ready=0.
  - On start: latch terms = (len==0) ? 2^CNT_W : len; set acc=0, cnt=0, ovf=0; go to ACCUM next cycle.
- ACCUM:
  - din_ready=1.
  - A transfer occurs when din_valid && din_ready. On a transfer: acc <= sat(acc + zero-extended din); cnt <= cnt+1.
  - If cnt == terms-1 at the transfer, go to DONE.
  - No transfer: hold state; bubbles are allowed.
- DONE:
  - dout_valid=1, dout=acc, dout_ovf=ovf, all held stable until taken.
  - din_ready=0.
  - On dout_ready: go to IDLE.
  - If start is also high that cycle: relatch len, clear acc/cnt/ovf, go directly to ACCUM. This gives a zero-bubble handoff.
- Latency: the final accepted term produces dout_valid=1 on the next rising edge.
- Saturation: if acc + din > 2^ACC_W-1, then acc = 2^ACC_W-1 and ovf=1 (sticky until the next start). Later terms keep acc at max.
- Width rule: din is unsigned and zero-extended to ACC_W+1 bits for the add; the carry-out detects saturation.
- start outside IDLE/DONE-handoff is ignored.
- clr:
  - Has priority over start, din and dout_ready in the same cycle.
  - Forces IDLE with acc/cnt/ovf=0. Any pending result is discarded.
- rst mid-ACCUM or mid-DONE: immediate return to reset values. Partial sums are lost.
- cnt wraps in CNT_W+1 bits internally, so a count of 2^CNT_W terms is representable.

Decomposition:
- Shared package alu_pkg contains:
  - state enum {ST_IDLE, ST_ACCUM, ST_DONE};
  - OP_MUL = 2'b11;
  - default width constants MUL_W=6, ACC_W=9.
- One sub-module: alu_sat_add (ACC_W-bit unsigned saturating adder, purely combinational; outputs sum and sat flag).
- The FSM and counters stay in alu_mac_accum.

Test Plan:
- Reset/idle: assert rst mid-cycle -> all outputs 0 immediately. With din_valid=1 in IDLE -> din_ready=0 and acc unchanged.
- Basic MAC: start with len=3; products 49, 6, 10 on consecutive cycles -> dout_valid one cycle after the third transfer, dout=65, dout_ovf=0, busy=1 until dout_ready.
- len=0 and bubbles: start with len=0 (8 terms); eight products of 49 with din_valid low every other cycle -> dout=392, ovf=0, exactly 8 transfers counted.
- Saturation (ACC_W=6 instance): start len=2; products 49, 49 -> dout=63, dout_ovf=1. The next run of len=1 with product 5 -> dout=5, dout_ovf=0.
- Backpressure and handoff: hold dout_ready=0 for 5 cycles -> dout stable. Then assert dout_ready and start (len=1) together -> ACCUM on the next cycle, no IDLE cycle, and the next result equals the first new product.
- Abort: clr during ACCUM after 2 of 4 terms, with start also high -> IDLE, acc=0. A fresh start with len=1 and product 7 -> dout=7.
